wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Parametrised N-master to 1-slave Wishbone classic arbiter. Successor to the fixed 3-CPU data/inst arbiter.
- Provides fair round-robin grant, a registered owner lock held until the transfer terminates, master abort handling and a bus-timeout watchdog that returns an error.
- Sits between the CPU cores and the shared memory/peripheral bus. The top level instantiates one copy for data and one for instruction fetch.

Parameters:
- NUM_M, 3, number of masters (2..8)
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max cycles a granted transfer may wait for ack/err; 0 disables the watchdog
- IDW, $clog2(NUM_M), width of the grant index (derived, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- m_cyc  in  NUM_M  per-master cycle request
- m_we  in  NUM_M  per-master write enable
- m_adr  in  NUM_M*AW  packed addresses; master i occupies [i*AW +: AW]
- m_dat_w  in  NUM_M*DW  packed write data
- m_dat_r  out  DW  slave read data, broadcast to all masters
- m_ack  out  NUM_M  per-master acknowledge
- m_err  out  NUM_M  per-master error (slave err or timeout)
- s_cyc  out  1  slave cycle
- s_stb  out  1  slave strobe
- s_we  out  1  slave write enable
- s_adr  out  AW  slave address
- s_dat_w  out  DW  slave write data
- s_dat_r  in  DW  slave read data
- s_ack  in  1  slave acknowledge
- s_err  in  1  slave error
- gnt_valid  out  1  bus currently owned
- gnt_id  out  IDW  current/last owner index

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - State=IDLE, gnt_valid=0, gnt_id=0, last=NUM_M-1, timer=0.
  - All s_* outputs are 0 and m_ack/m_err are 0 in reset and in IDLE.
- FSM states: IDLE, OWN, REL.
- IDLE:
  - If any m_cyc is set, pick the first requester scanning from (last+1) mod NUM_M upward with wrap.
  - Register the winner into gnt_id, set gnt_valid=1, go to OWN.
  - Grant latency is 1 cycle from the m_cyc rise to s_cyc/s_stb.
- OWN:
  - s_cyc = s_stb = m_cyc[gnt_id].
  - s_we, s_adr and s_dat_w are muxed from gnt_id using an index mux, not AND-OR.
  - m_ack[gnt_id] = s_ack and m_err[gnt_id] = s_err, combinationally. All other bits are 0.
  - Transition to REL on the first of the following; the highest listed wins when simultaneous:
    - s_err;
    - s_ack, with s_ack and s_err together treated as err only;
    - owner drops m_cyc (abort, no ack/err issued);
    - timer == TIMEOUT-1 with TIMEOUT != 0, which pulses m_err[gnt_id] for 1 cycle with s_stb still high.
  - Entering REL sets last=gnt_id and clears timer.
- timer:
  - Increments each OWN cycle without ack/err and saturates.
  - Clears in IDLE and REL.
- REL:
  - s_cyc=s_stb=0 and gnt_valid=0 for exactly 1 cycle, then IDLE.
  - This guarantees one dead cycle between owners and lets a master re-request.
  - gnt_id holds its value through REL and IDLE.
- Back-to-back: the same master re-requesting while others wait loses to the next index. With NUM_M masters all requesting, each gets exactly one transfer per NUM_M grants.
- m_dat_r = s_dat_r always; it is qualified only by m_ack.
- Slave ack/err while not in OWN is ignored; no m_ack/m_err is produced.
- Reset asserted mid-OWN drops s_cyc on the next edge; no ack is forwarded after reset.
- Requester index >= NUM_M is unreachable; the IDW-wide wrap compares against NUM_M, not 2^IDW.

Decomposition:
- Shared package (wb_pkg):
  - state encoding localparams IDLE/OWN/REL;
  - the IDW derivation function;
  - the Wishbone width defaults matching the DataWidth/PcWidth defines.
- One sub-module: rr_pick, a combinational round-robin picker.
  - Inputs: req[NUM_M], last[IDW].
  - Outputs: any, idx[IDW].
  - Reused by the future interrupt arbiter.

Test Plan:
- Single request: m_cyc=3'b010 at cycle 0, slave acks at cycle 3.
  - Expect s_cyc=1 at cycles 1-3 with s_adr = master1 address.
  - Expect m_ack=3'b010 at cycle 3, s_cyc=0 at cycle 4 (REL), gnt_id=1.
- Fairness: all 3 masters hold m_cyc continuously and the slave acks after 1 cycle.
  - Expect grant order 0,1,2,0,1,2 with exactly one REL cycle between grants.
- Abort: master 2 owns the bus and drops m_cyc before ack, while master 0 is requesting.
  - Expect s_cyc=0 the same cycle, REL next, then grant to 0, with no m_ack/m_err to master 2.
- Timeout: TIMEOUT=4 and slave never acks.
  - Expect m_err[owner]=1 on the 4th OWN cycle, then REL, and the bus re-arbitrates.
  - Repeat with TIMEOUT=0: expect the bus held indefinitely.
- Error precedence: s_ack=1 and s_err=1 in the same cycle.
  - Expect m_err=1 and m_ack=0 for the owner.
  - Expect stray s_ack in IDLE to produce no m_ack.
- Reset mid-transfer: assert rst during OWN.
  - Expect all outputs 0 next cycle, gnt_valid=0.
  - Expect the first post-reset grant to go to master 0 when all are requesting.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter definitions: FSM encoding, bus widths
// and the grant-index width helper.
package wb_pkg;

   localparam int WB_DW = 32;
   localparam int WB_AW = 32;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN  = 2'd1;
   localparam logic [1:0] REL  = 2'd2;

   function automatic int idw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester scanning
// upward from last+1, wrapping at NUM_M.
module rr_pick
   import wb_pkg::*;
#(
   parameter  int NUM_M = 3,
   localparam int IDW   = idw_of(NUM_M)
) (
   input  logic [NUM_M-1:0] req,
   input  logic [IDW-1:0]   last,
   output logic             any,
   output logic [IDW-1:0]   idx
);

   logic [IDW-1:0] cand;

   // Scan farthest-first so the nearest requester is assigned last.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = '0;
      for (int k = NUM_M; k >= 1; k--) begin
         cand = IDW'((int'(last) + k) % NUM_M);
         if (req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone classic arbiter with round-robin
// grant, owner lock, abort handling and a timeout watchdog.
module wb_rr_arbiter
   import wb_pkg::*;
#(
   parameter  int NUM_M   = 3,
   parameter  int AW      = WB_AW,
   parameter  int DW      = WB_DW,
   parameter  int TIMEOUT = 255,
   localparam int IDW     = idw_of(NUM_M)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_M-1:0]    m_cyc,
   input  logic [NUM_M-1:0]    m_we,
   input  logic [NUM_M*AW-1:0] m_adr,
   input  logic [NUM_M*DW-1:0] m_dat_w,
   output logic [DW-1:0]       m_dat_r,
   output logic [NUM_M-1:0]    m_ack,
   output logic [NUM_M-1:0]    m_err,
   output logic                s_cyc,
   output logic                s_stb,
   output logic                s_we,
   output logic [AW-1:0]       s_adr,
   output logic [DW-1:0]       s_dat_w,
   input  logic [DW-1:0]       s_dat_r,
   input  logic                s_ack,
   input  logic                s_err,
   output logic                gnt_valid,
   output logic [IDW-1:0]      gnt_id
);

   localparam int TW = $clog2(TIMEOUT + 2);

   logic [1:0]     state;
   logic [IDW-1:0] last;
   logic [TW-1:0]  timer;
   logic           pick_any;
   logic [IDW-1:0] pick_idx;
   logic           own;
   logic           own_cyc;
   logic           to_hit;
   logic           done;

   logic [AW-1:0]  adr_a [NUM_M];
   logic [DW-1:0]  dat_a [NUM_M];

   for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
      assign adr_a[i] = m_adr[i*AW +: AW];
      assign dat_a[i] = m_dat_w[i*DW +: DW];
   end

   rr_pick #(
      .NUM_M (NUM_M)
   ) u_pick (
      .req  (m_cyc),
      .last (last),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   assign own     = (state == OWN);
   assign own_cyc = m_cyc[gnt_id];
   assign to_hit  = own && own_cyc && !s_ack && !s_err &&
                    (TIMEOUT != 0) &&
                    (timer == TW'(TIMEOUT - 1));
   // Release causes in priority order: err, ack, abort, timeout.
   assign done    = s_err || s_ack || !own_cyc || to_hit;
   assign m_dat_r = s_dat_r;

   always_comb begin
      s_cyc   = 1'b0;
      s_stb   = 1'b0;
      s_we    = 1'b0;
      s_adr   = '0;
      s_dat_w = '0;
      m_ack   = '0;
      m_err   = '0;
      if (own) begin
         s_cyc   = own_cyc;
         s_stb   = own_cyc;
         s_we    = m_we[gnt_id];
         s_adr   = adr_a[gnt_id];
         s_dat_w = dat_a[gnt_id];
         if (s_err || to_hit)
            m_err[gnt_id] = 1'b1;
         else if (s_ack)
            m_ack[gnt_id] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
         last      <= IDW'(NUM_M - 1);
         timer     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               timer <= '0;
               if (pick_any) begin
                  gnt_id    <= pick_idx;
                  gnt_valid <= 1'b1;
                  state     <= OWN;
               end
            end
            OWN: begin
               if (done) begin
                  state     <= REL;
                  gnt_valid <= 1'b0;
                  last      <= gnt_id;
                  timer     <= '0;
               end else if (timer != '1) begin
                  timer <= timer + 1'b1;
               end
            end
            REL: begin
               state <= IDLE;
               timer <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomized and directed bench for wb_rr_arbiter against a
// transaction-level reference model.
module tb_wb_rr_arbiter;

   localparam int NM = 3;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  m_cyc = '0;
   logic [2:0]  m_we = '0;
   logic [31:0] adr [NM];
   logic [31:0] dw  [NM];
   logic [95:0] m_adr;
   logic [95:0] m_dat_w;
   logic [31:0] m_dat_r;
   logic [2:0]  m_ack;
   logic [2:0]  m_err;
   logic        s_cyc;
   logic        s_stb;
   logic        s_we;
   logic [31:0] s_adr;
   logic [31:0] s_dat_w;
   logic [31:0] s_dat_r = '0;
   logic        s_ack = 1'b0;
   logic        s_err = 1'b0;
   logic        gnt_valid;
   logic [1:0]  gnt_id;

   logic        nrst = 1'b1;
   logic [2:0]  n_cyc = '0;
   logic [2:0]  n_we = '0;
   logic [95:0] n_adr = 96'h3;
   logic [95:0] n_dw = '0;
   logic [31:0] n_dat_r;
   logic [2:0]  n_ack;
   logic [2:0]  n_err;
   logic        n_s_cyc;
   logic        n_s_stb;
   logic        n_s_we;
   logic [31:0] n_s_adr;
   logic [31:0] n_s_dw;
   logic [1:0]  n_gid;
   logic        n_gv;

   assign m_adr   = {adr[2], adr[1], adr[0]};
   assign m_dat_w = {dw[2], dw[1], dw[0]};

   always #5 clk = ~clk;

   wb_rr_arbiter #(
      .NUM_M (NM), .AW (32), .DW (32), .TIMEOUT (TO)
   ) dut (
      .clk (clk), .rst (rst),
      .m_cyc (m_cyc), .m_we (m_we), .m_adr (m_adr),
      .m_dat_w (m_dat_w), .m_dat_r (m_dat_r),
      .m_ack (m_ack), .m_err (m_err),
      .s_cyc (s_cyc), .s_stb (s_stb), .s_we (s_we),
      .s_adr (s_adr), .s_dat_w (s_dat_w), .s_dat_r (s_dat_r),
      .s_ack (s_ack), .s_err (s_err),
      .gnt_valid (gnt_valid), .gnt_id (gnt_id)
   );

   wb_rr_arbiter #(
      .NUM_M (NM), .AW (32), .DW (32), .TIMEOUT (0)
   ) dut_nt (
      .clk (clk), .rst (nrst),
      .m_cyc (n_cyc), .m_we (n_we), .m_adr (n_adr),
      .m_dat_w (n_dw), .m_dat_r (n_dat_r),
      .m_ack (n_ack), .m_err (n_err),
      .s_cyc (n_s_cyc), .s_stb (n_s_stb), .s_we (n_s_we),
      .s_adr (n_s_adr), .s_dat_w (n_s_dw), .s_dat_r (32'h0),
      .s_ack (1'b0), .s_err (1'b0),
      .gnt_valid (n_gv), .gnt_id (n_gid)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: owner (-1 when bus free), one dead cycle flag,
   // rotation pointer, displayed grant and wait counter.
   int   own = -1;
   bit   gap = 1'b0;
   int   last = NM - 1;
   int   gid = 0;
   int   waits = 0;
   bit   e_hit;
   logic [2:0] e_ack = '0;
   logic [2:0] e_err = '0;
   bit   rec = 1'b0;
   logic gv_prev = 1'b0;
   int   grants[$];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check();
      logic       ec, ewe;
      logic [31:0] ea, ed;
      logic [2:0] ka, ke;
      bit         hit;
      ec = 0; ewe = 0; ea = 0; ed = 0; ka = 0; ke = 0; hit = 0;
      if (own >= 0) begin
         ec  = m_cyc[own];
         ewe = m_we[own];
         ea  = adr[own];
         ed  = dw[own];
         hit = (waits == TO - 1) && m_cyc[own] && !s_ack && !s_err;
         if (s_err || hit) ke[own] = 1'b1;
         else if (s_ack)   ka[own] = 1'b1;
      end
      e_ack = ka;
      e_err = ke;
      e_hit = hit;
      chk("s_cyc", s_cyc, ec);
      chk("s_stb", s_stb, ec);
      chk("s_we", s_we, ewe);
      chk("s_adr", s_adr, ea);
      chk("s_dat_w", s_dat_w, ed);
      chk("m_ack", m_ack, ka);
      chk("m_err", m_err, ke);
      chk("m_dat_r", m_dat_r, s_dat_r);
      chk("gnt_valid", gnt_valid, own >= 0);
      chk("gnt_id", gnt_id, gid);
   endtask

   task automatic advance();
      if (rst) begin
         own = -1; gap = 0; last = NM - 1; gid = 0; waits = 0;
      end else if (own >= 0) begin
         if (s_err || s_ack || !m_cyc[own] || e_hit) begin
            last = own; own = -1; gap = 1; waits = 0;
         end else if (waits < 1000) begin
            waits++;
         end
      end else if (gap) begin
         gap = 0;
      end else begin
         for (int k = 1; k <= NM; k++) begin
            int c;
            c = (last + k) % NM;
            if (m_cyc[c]) begin
               own = c; gid = c;
               break;
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic [2:0] c,
                       input logic a, input logic e);
      rst = r; m_cyc = c; s_ack = a; s_err = e;
      s_dat_r = $urandom;
      #2;
      check();
      if (rec && gnt_valid && !gv_prev) grants.push_back(int'(gnt_id));
      gv_prev = gnt_valid;
      advance();
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] cyc;
      int r;
      for (int i = 0; i < NM; i++) begin
         adr[i] = 32'h1000_0000 * (i + 1) + 32'h40;
         dw[i]  = 32'hA5A5_0000 + i;
      end
      m_we = 3'b101;
      repeat (2) @(negedge clk);

      step(1, 3'b000, 0, 0);
      step(1, 3'b111, 1, 1);

      // single request from master 1, ack on third owned cycle
      step(0, 3'b010, 0, 0);
      step(0, 3'b010, 0, 0);
      step(0, 3'b010, 0, 0);
      step(0, 3'b010, 1, 0);
      step(0, 3'b000, 0, 0);
      #2 chk("single_gnt", gnt_id, 1);

      // ack and err together, then a stray ack while idle
      step(0, 3'b001, 0, 0);
      m_cyc = 3'b001; s_ack = 1; s_err = 1;
      #1 chk("prec_err", m_err, 3'b001);
      chk("prec_ack", m_ack, 3'b000);
      step(0, 3'b001, 1, 1);
      step(0, 3'b000, 0, 0);
      m_cyc = 3'b000; s_ack = 1; s_err = 0;
      #1 chk("stray_ack", m_ack, 3'b000);
      step(0, 3'b000, 1, 0);

      // abort by master 2 with master 0 waiting
      step(1, 3'b000, 0, 0);
      step(0, 3'b100, 0, 0);
      step(0, 3'b101, 0, 0);
      m_cyc = 3'b001; s_ack = 0; s_err = 0;
      #1 chk("abort_cyc", s_cyc, 0);
      chk("abort_resp", {m_ack, m_err}, 6'b0);
      step(0, 3'b001, 0, 0);
      step(0, 3'b001, 0, 0);
      step(0, 3'b001, 0, 0);
      #2 chk("abort_gnt", gnt_id, 0);
      chk("abort_gv", gnt_valid, 1);

      // watchdog: slave never answers
      step(1, 3'b000, 0, 0);
      step(0, 3'b010, 0, 0);
      repeat (3) step(0, 3'b010, 0, 0);
      m_cyc = 3'b010; s_ack = 0; s_err = 0;
      #1 chk("to_err", m_err, 3'b010);
      chk("to_stb", s_stb, 1);
      step(0, 3'b010, 0, 0);
      step(0, 3'b010, 0, 0);
      step(0, 3'b010, 0, 0);
      #2 chk("to_regrant", gnt_valid, 1);

      // fairness with everyone requesting
      step(1, 3'b000, 0, 0);
      rec = 1;
      repeat (20) step(0, 3'b111, 1, 0);
      rec = 0;
      chk("fair_n", grants.size() >= 6, 1);
      for (int i = 0; i < 6 && i < grants.size(); i++)
         chk("fair_ord", grants[i], i % NM);

      // reset while master 1 owns the bus
      step(1, 3'b000, 0, 0);
      step(0, 3'b111, 0, 0);
      step(0, 3'b111, 1, 0);
      step(0, 3'b111, 0, 0);
      step(0, 3'b111, 0, 0);
      step(0, 3'b111, 0, 0);
      step(1, 3'b111, 0, 0);
      s_ack = 1;
      #1 chk("rst_cyc", s_cyc, 0);
      chk("rst_gv", gnt_valid, 0);
      chk("rst_ack", m_ack, 3'b000);
      step(0, 3'b111, 0, 0);
      #2 chk("post_rst_gnt", gnt_id, 0);
      chk("post_rst_gv", gnt_valid, 1);

      // randomized traffic
      step(1, 3'b000, 0, 0);
      cyc = '0;
      repeat (1500) begin
         for (int i = 0; i < NM; i++) begin
            if (!cyc[i]) begin
               if ($urandom_range(0, 99) < 35) begin
                  cyc[i]  = 1'b1;
                  adr[i]  = $urandom;
                  dw[i]   = $urandom;
                  m_we[i] = 1'($urandom_range(0, 1));
               end
            end else if (e_ack[i] || e_err[i]) begin
               if ($urandom_range(0, 1) == 0) begin
                  cyc[i] = 1'b0;
               end else begin
                  adr[i] = $urandom;
                  dw[i]  = $urandom;
               end
            end else if ($urandom_range(0, 99) < 4) begin
               cyc[i] = 1'b0;
            end
         end
         r = $urandom_range(0, 99);
         step($urandom_range(0, 299) == 0, cyc,
              (r < 30) || (r >= 92), r >= 85);
      end

      // watchdog disabled: bus stays held
      @(negedge clk);
      nrst = 1'b0;
      n_cyc = 3'b001;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #2;
         chk("nt_cyc", n_s_cyc, 1);
         chk("nt_err", n_err, 3'b000);
      end
      chk("nt_gv", n_gv, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
